// File: rtl/prbs_roll_controller_pkg.sv
// Shared state encoding and widths for the PRBS dice-roll controller.
package prbs_roll_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2,
        SHOW = 2'd3
    } roll_state_t;

    localparam int ROLL_COUNT_W = 8;
endpackage

// File: rtl/prbs_roll_controller_key_debouncer.sv
// Pushbutton conditioning: 2-flop synchroniser, stability counter and
// single-cycle press/release events derived from the debounced level.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_comb begin
        sync1_d = i_key_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Events fire in the cycle the debounced level has just changed.
        press_d   = deb_q & ~deb_d;
        release_d = ~deb_q & deb_d;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_press   = press_q;
    assign o_release = release_q;
endmodule

// File: rtl/prbs_roll_controller.sv
// Dice-roll sequencer for the PRBS display: fast spin while held, doubling
// slowdown after release, then capture. PRBS_ROLL_BLANK_EN adds o_blank flicker.
module prbs_roll_controller
    import prbs_roll_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FAST_PERIOD     = 2500000,
    parameter int SLOW_STEPS      = 8,
    parameter int CNT_W           = 32
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_key_n,
    output logic                    o_step,
    output logic                    o_capture,
    output logic                    o_busy,
    output logic [1:0]              o_state,
    output logic [ROLL_COUNT_W-1:0] o_rollCount
`ifdef PRBS_ROLL_BLANK_EN
    ,
    output logic                    o_blank
`endif
);
    localparam longint unsigned PERIOD_MAX = 64'(FAST_PERIOD) << SLOW_STEPS;
    localparam int IW = $clog2(SLOW_STEPS + 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(SLOW_STEPS);
    localparam logic [CNT_W-1:0] FAST_P   = CNT_W'(FAST_PERIOD);

    generate
        if (FAST_PERIOD < 2 || SLOW_STEPS < 1 ||
            (CNT_W < 64 && PERIOD_MAX >= (64'd1 << CNT_W))) begin : g_bad_cfg
            $error("prbs_roll_controller: FAST_PERIOD << SLOW_STEPS must fit in CNT_W bits");
        end
    endgenerate

    logic press, release_ev;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_key_n  (i_key_n),
        .o_press  (press),
        .o_release(release_ev)
    );

    roll_state_t             state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    step_q, step_d;
    logic                    capture_q, capture_d;
    logic                    busy_q, busy_d;
    logic [ROLL_COUNT_W-1:0] count_q, count_d;
    logic                    expire;
`ifdef PRBS_ROLL_BLANK_EN
    logic                    blank_q, blank_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        period_d  = period_q;
        idx_d     = idx_q;
        step_d    = 1'b0;
        capture_d = 1'b0;
        count_d   = count_q;
        expire    = (timer_q == period_q - CNT_W'(1));
        case (state_q)
            IDLE, SHOW: begin
                if (press) begin
                    state_d  = SPIN;
                    timer_d  = '0;
                    period_d = FAST_P;
                end
            end
            SPIN: begin
                timer_d = timer_q + CNT_W'(1);
                if (expire) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                end
                if (release_ev) begin
                    state_d  = SLOW;
                    idx_d    = '0;
                    timer_d  = '0;
                    period_d = FAST_P << 1;
                end
            end
            SLOW: begin
                // Final step is already on o_step; capture lands one cycle later.
                if (idx_q == IDX_LAST) begin
                    state_d   = SHOW;
                    capture_d = 1'b1;
                    count_d   = count_q + ROLL_COUNT_W'(1);
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                    if (expire) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                        idx_d   = idx_q + IW'(1);
                        if (idx_q != IDX_LAST - IW'(1)) begin
                            period_d = period_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SPIN) || (state_d == SLOW);
`ifdef PRBS_ROLL_BLANK_EN
        blank_d = blank_q;
        if (step_d) begin
            blank_d = ~blank_q;
        end
        if (capture_d) begin
            blank_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            period_q  <= '0;
            idx_q     <= '0;
            step_q    <= 1'b0;
            capture_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
`ifdef PRBS_ROLL_BLANK_EN
            blank_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            capture_q <= capture_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
`ifdef PRBS_ROLL_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign o_step      = step_q;
    assign o_capture   = capture_q;
    assign o_busy      = busy_q;
    assign o_state     = state_q;
    assign o_rollCount = count_q;
`ifdef PRBS_ROLL_BLANK_EN
    assign o_blank     = blank_q;
`endif
endmodule

// File: tb/tb_prbs_roll_controller.sv
// Directed bench for prbs_roll_controller with small timing parameters.
module tb_prbs_roll_controller;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int FAST_PERIOD     = 3;
    localparam int SLOW_STEPS      = 2;
    localparam int CNT_W           = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       step, capture, busy;
    logic [1:0] state;
    logic [7:0] roll_count;
`ifdef PRBS_ROLL_BLANK_EN
    logic       blank;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prbs_roll_controller #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .FAST_PERIOD    (FAST_PERIOD),
        .SLOW_STEPS     (SLOW_STEPS),
        .CNT_W          (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_arst_n   (rst_n),
        .i_key_n    (key_n),
        .o_step     (step),
        .o_capture  (capture),
        .o_busy     (busy),
        .o_state    (state),
        .o_rollCount(roll_count)
`ifdef PRBS_ROLL_BLANK_EN
        ,
        .o_blank    (blank)
`endif
    );

    typedef struct {
        int         ncyc;
        logic       key_n;
        logic [1:0] st;
        logic       stp;
        logic       cap;
        logic       bsy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle invariants while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (step && capture) begin
                errors++;
                $display("FAIL step_capture_overlap: got step=%0b capture=%0b expected not both", step, capture);
            end
            checks++;
            if (step && (state == 2'd0 || state == 2'd3)) begin
                errors++;
                $display("FAIL step_in_idle_show: got step=1 in state %0d expected 0", state);
            end
        end
    end

    task automatic do_roll();
        int n;
        key_n = 1'b0;
        repeat (8) tick();
        key_n = 1'b1;
        n = 0;
        while (capture !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (capture !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL roll_timeout: got no capture within %0d cycles expected capture", n);
        end
        repeat (2) tick();
    endtask

    initial begin
        // Roll 1: held 30 cycles, release coincides with a SPIN step.
        vecs.push_back('{5,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{2,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{2,  1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{17, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{4,  1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{2,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{5,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{11, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1});
        vecs.push_back('{20, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1});
        // Roll 2: press from SHOW, plain release, press during SLOW ignored.
        vecs.push_back('{7,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{3,  1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{5,  1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{5,  1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{6,  1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{5,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd2});
        vecs.push_back('{10, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd2});

        rst_n = 1'b0;
        key_n = 1'b1;
        repeat (3) tick();
        check("reset.state", 32'(state), 32'd0);
        check("reset.step", 32'(step), 32'd0);
        check("reset.capture", 32'(capture), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.count", 32'(roll_count), 32'd0);
`ifdef PRBS_ROLL_BLANK_EN
        check("reset.blank", 32'(blank), 32'd1);
`endif
        rst_n = 1'b1;
        repeat (2) tick();

        // Short glitch must not be accepted as a press.
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("glitch%0d.state", i), 32'(state), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            key_n = vecs[i].key_n;
            repeat (vecs[i].ncyc) tick();
            check($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d.step", i), 32'(step), 32'(vecs[i].stp));
            check($sformatf("v%0d.capture", i), 32'(capture), 32'(vecs[i].cap));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("v%0d.count", i), 32'(roll_count), 32'(vecs[i].cnt));
        end
`ifdef PRBS_ROLL_BLANK_EN
        check("show.blank", 32'(blank), 32'd0);
`endif

        // Roll counter wrap: 2 rolls done, 253 more reach 255, one more wraps.
        for (int r = 0; r < 253; r++) do_roll();
        check("count_255", 32'(roll_count), 32'd255);
        do_roll();
        check("count_wrap", 32'(roll_count), 32'd0);
        check("wrap.state", 32'(state), 32'd3);

        // Asynchronous reset mid-roll, on a cycle where o_step is high.
        begin
            int n;
            key_n = 1'b0;
            repeat (8) tick();
            key_n = 1'b1;
            n = 0;
            while (state !== 2'd2 && n < 100) begin
                tick();
                n++;
            end
            check("midroll.in_slow", 32'(state), 32'd2);
            repeat (6) tick();
            check("midroll.step", 32'(step), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst.state", 32'(state), 32'd0);
            check("async_rst.step", 32'(step), 32'd0);
            check("async_rst.capture", 32'(capture), 32'd0);
            check("async_rst.busy", 32'(busy), 32'd0);
            check("async_rst.count", 32'(roll_count), 32'd0);
            tick();
            rst_n = 1'b1;
            repeat (40) tick();
            check("post_rst.state", 32'(state), 32'd0);
            check("post_rst.count", 32'(roll_count), 32'd0);
`ifdef PRBS_ROLL_BLANK_EN
            check("post_rst.blank", 32'(blank), 32'd1);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by time limit expected $finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/prbs_roll_controller.md
Name: prbs_roll_controller

Overview:
- Sequences the 7-bit PRBS behind the two seven-segment displays as a "dice roll" driven by one pushbutton.
- While the key is held, the PRBS steps at a fast fixed rate. On release, the step interval doubles for a fixed number of steps, then the result is captured for display.
- Drives the PRBS step-enable and the display capture strobe. The PRBS itself and the hex decoders sit outside this block.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised key level must be stable before it is accepted (20 ms at 50 MHz).
- FAST_PERIOD, 2500000, cycles between steps while the key is held; must be >= 2.
- SLOW_STEPS, 8, number of decelerating steps after release; must be >= 1.
- CNT_W, 32, timer width; elaboration error unless FAST_PERIOD << SLOW_STEPS < 2**CNT_W.

Ports:
- i_clk  in  1  system clock.
- i_arst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- i_key_n  in  1  raw pushbutton, asynchronous, 0 = pressed.
- o_step  out  1  one-cycle pulse; PRBS advances on the next i_clk edge.
- o_capture  out  1  one-cycle pulse; display register loads the PRBS value.
- o_busy  out  1  high in SPIN or SLOW.
- o_state  out  2  current FSM state encoding.
- o_rollCount  out  8  number of completed rolls, modulo 256.

Behaviour:
- Reset (i_arst_n=0), effective immediately:
  - State IDLE; o_step, o_capture and o_busy are 0; o_rollCount is 0.
  - Timer and slow index are 0; debounced key is 1 (released); synchroniser flops are 1.
- Key path:
  - 2-flop synchroniser, then debounce counter.
  - The counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - press = debounced 1->0; release = debounced 0->1; each is a single-cycle event.
- State encodings: IDLE=0, SPIN=1, SLOW=2, SHOW=3.
- IDLE:
  - press -> SPIN with timer=0 and period=FAST_PERIOD.
- SPIN:
  - Timer increments each cycle. When timer==period-1, pulse o_step and set timer=0.
  - First step comes FAST_PERIOD cycles after SPIN entry.
  - release -> SLOW with slow index=0, timer=0, period=FAST_PERIOD<<1.
  - If release and timer expiry coincide, o_step is still emitted that cycle, then SLOW is entered with timer=0.
- SLOW:
  - On timer==period-1: pulse o_step, timer=0, slow index+1, period<<=1.
  - When the step that brings the slow index to SLOW_STEPS is emitted, the next state is SHOW.
  - press is ignored in SLOW; the roll always completes.
- SHOW:
  - o_capture pulses on the first SHOW cycle, exactly one cycle after the final o_step, so the PRBS has already updated.
  - o_rollCount increments in that same cycle and wraps 255->0.
  - The state then holds indefinitely; press -> SPIN (new roll) as from IDLE.
- General rules:
  - o_step never asserts in IDLE or SHOW.
  - o_step and o_capture are never high in the same cycle.
  - Reset mid-roll aborts with no capture.
- Timer arithmetic is unsigned CNT_W; the period register is CNT_W bits and never overflows, given the elaboration check.

Optional Feature:
- Macro: PRBS_ROLL_BLANK_EN.
- With the macro defined: extra output port o_blank (1 bit), registered, reset 1.
  - o_blank = 1 in IDLE.
  - In SPIN/SLOW, o_blank toggles on every o_step so the displays flicker during a roll.
  - o_blank = 0 in SHOW, from the o_capture cycle onward.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package prbs_roll_pkg holds:
  - typedef enum logic [1:0] roll_state_t {IDLE, SPIN, SLOW, SHOW} with the encodings above;
  - localparam ROLL_COUNT_W = 8.
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES) contains the synchroniser, the debounce counter and the press/release event pulses. The controller FSM and timer stay in prbs_roll_controller.

Test Plan (DEBOUNCE_CYCLES=4, FAST_PERIOD=3, SLOW_STEPS=2, CNT_W=8):
- Reset: assert i_arst_n=0 mid-run -> all outputs 0, o_state=0 in the same cycle, with no clock edge needed.
- Glitch: i_key_n low for 3 cycles then high -> no press, o_state stays 0, o_step never pulses.
- Hold: i_key_n low for 30 cycles -> SPIN entered; o_step pulses at 3-cycle spacing starting 3 cycles after entry; o_busy=1.
- Release: the first slow step comes 6 cycles after SLOW entry and the second 12 cycles after that. o_capture comes exactly 1 cycle after the second step. o_state=3, o_rollCount=1, o_busy=0.
- Press during SLOW -> ignored and the roll completes as above. A press in SHOW -> SPIN; after 256 completed rolls, o_rollCount wraps to 0.
- Coincidence: release event on the cycle timer==2 in SPIN -> o_step that cycle, SLOW entered with timer=0, next step 6 cycles later.
